// File: rtl/dma_burst_scheduler.sv
// dma_burst_scheduler
// Round-robin arbiter that owns the single AXI burst engine on behalf of the
// IFM-read, weight-read and OFM-write requesters. Each accepted transfer is
// cut into bursts of at most MAX_BURST beats that never cross a BOUNDARY-byte
// line, and exactly one burst is in flight at a time.
//
// Optional build macro: DMA_SCHED_WATCHDOG_EN
//   Adds a per-command watchdog. Time spent in ISSUE or WAIT is counted and,
//   after TIMEOUT_CYCLES, the transfer is abandoned (no req_done) and the
//   sticky err flag is raised. Without the macro err is tied to 0 and the
//   block waits for cmd_ready / burst_done indefinitely.
//
// Handshake semantics: a command transfers on a cycle where cmd_valid and
// cmd_ready are both high; once cmd_valid rises, cmd_addr/cmd_len/cmd_write/
// cmd_id stay constant and cmd_valid stays high until that transfer cycle.
// A request transfers on a cycle where req_valid[i] and req_ready[i] are
// high; req_ready is a one-hot, IDLE-only, single-cycle grant.
module dma_burst_scheduler #(
    parameter int NUM_REQ        = 3,
    parameter int ADDR_WIDTH     = 32,
    parameter int LEN_WIDTH      = 16,
    parameter int MAX_BURST      = 256,
    parameter int BEAT_BYTES     = 16,
    parameter int BOUNDARY       = 4096,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int ID_W           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]  req_beats,
    input  logic [NUM_REQ-1:0]            req_write,
    output logic [NUM_REQ-1:0]            req_done,
    output logic                          cmd_valid,
    input  logic                          cmd_ready,
    output logic [ADDR_WIDTH-1:0]         cmd_addr,
    output logic [7:0]                    cmd_len,
    output logic                          cmd_write,
    output logic [ID_W-1:0]               cmd_id,
    input  logic                          burst_done,
    output logic                          busy,
    output logic                          err,
    output logic [1:0]                    dbg_state
);

    localparam int BYTE_SH   = $clog2(BEAT_BYTES);
    localparam int BND_SH    = $clog2(BOUNDARY);
    localparam int BND_BEATS = BOUNDARY / BEAT_BYTES;
    localparam int BLEN_MAX  = (MAX_BURST > BND_BEATS) ? MAX_BURST : BND_BEATS;
    localparam int BLEN_W    = $clog2(BLEN_MAX + 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'(BEAT_BYTES - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CALC  = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;
    localparam logic [1:0] S_WAIT  = 2'd3;

    logic [1:0]            r_state;
    logic [1:0]            w_next_state;
    logic [ID_W-1:0]       r_ptr;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LEN_WIDTH-1:0]  r_rem;
    logic [BLEN_W-1:0]     r_blen;
    logic                  r_write;
    logic [ID_W-1:0]       r_id;
    logic [ADDR_WIDTH-1:0] r_cmd_addr;
    logic [7:0]            r_cmd_len;
    logic [NUM_REQ-1:0]    r_done;

    logic                  w_grant_vld;
    logic [ID_W-1:0]       w_grant_id;
    logic [NUM_REQ-1:0]    w_grant_onehot;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [LEN_WIDTH-1:0]  w_sel_beats;
    logic [BLEN_W-1:0]     w_to_bnd;
    logic [BLEN_W-1:0]     w_cap;
    logic [BLEN_W-1:0]     w_blen;
    logic [ADDR_WIDTH-1:0] w_next_addr;
    logic [LEN_WIDTH-1:0]  w_next_rem;
    logic                  w_timeout;

    // Requester index reached k steps after p, wrapping modulo NUM_REQ.
    function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return ID_W'(s);
    endfunction

    // Round-robin search: first asserted request at or after the pointer.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_id  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[rr_idx(r_ptr, k)]) begin
                w_grant_vld = 1'b1;
                w_grant_id  = rr_idx(r_ptr, k);
            end
        end
    end

    assign w_grant_onehot = NUM_REQ'(1) << w_grant_id;
    assign w_sel_addr     = req_addr[w_grant_id*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_sel_beats    = req_beats[w_grant_id*LEN_WIDTH +: LEN_WIDTH];

    // Burst sizing: the shortest of what is left, the AXI cap and the beats
    // remaining before the next boundary line.
    assign w_to_bnd    = BLEN_W'(BND_BEATS) - BLEN_W'(r_addr[BND_SH-1:BYTE_SH]);
    assign w_cap       = (BLEN_W'(MAX_BURST) < w_to_bnd) ? BLEN_W'(MAX_BURST) : w_to_bnd;
    assign w_blen      = (r_rem < LEN_WIDTH'(w_cap)) ? BLEN_W'(r_rem) : w_cap;
    assign w_next_addr = r_addr + (ADDR_WIDTH'(r_blen) << BYTE_SH);
    assign w_next_rem  = r_rem - LEN_WIDTH'(r_blen);

    // Next-state decision; a completed handshake or burst wins over a timeout.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_grant_vld)
                    w_next_state = (w_sel_beats == '0) ? S_IDLE : S_CALC;
            end
            S_CALC: w_next_state = S_ISSUE;
            S_ISSUE: begin
                if (cmd_ready)
                    w_next_state = S_WAIT;
                else if (w_timeout)
                    w_next_state = S_IDLE;
            end
            S_WAIT: begin
                if (burst_done)
                    w_next_state = (w_next_rem == '0) ? S_IDLE : S_CALC;
                else if (w_timeout)
                    w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // State register plus transfer bookkeeping and the req_done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_addr     <= '0;
            r_rem      <= '0;
            r_blen     <= '0;
            r_write    <= 1'b0;
            r_id       <= '0;
            r_cmd_addr <= '0;
            r_cmd_len  <= '0;
            r_done     <= '0;
        end else begin
            r_state <= w_next_state;
            r_done  <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_vld) begin
                        r_ptr   <= rr_idx(w_grant_id, 1);
                        r_addr  <= w_sel_addr & ADDR_MASK;
                        r_rem   <= w_sel_beats;
                        r_write <= req_write[w_grant_id];
                        r_id    <= w_grant_id;
                        if (w_sel_beats == '0)
                            r_done <= w_grant_onehot;
                    end
                end
                S_CALC: begin
                    r_blen     <= w_blen;
                    r_cmd_addr <= r_addr;
                    r_cmd_len  <= 8'(w_blen - BLEN_W'(1));
                end
                S_WAIT: begin
                    if (burst_done) begin
                        r_addr <= w_next_addr;
                        r_rem  <= w_next_rem;
                        if (w_next_rem == '0)
                            r_done <= NUM_REQ'(1) << r_id;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DMA_SCHED_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] r_wd_cnt;
    logic            r_err;

    assign w_timeout = ((r_state == S_ISSUE) || (r_state == S_WAIT)) &&
                       (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

    // Watchdog: restart on every entry to ISSUE/WAIT, count while there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wd_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_next_state != r_state)
                r_wd_cnt <= '0;
            else if ((r_state == S_ISSUE) || (r_state == S_WAIT))
                r_wd_cnt <= r_wd_cnt + WD_W'(1);
            if (w_timeout && (w_next_state == S_IDLE))
                r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    // Outputs; the grant is gated by rst so every output reads 0 in reset.
    assign req_ready = ((r_state == S_IDLE) && w_grant_vld && !rst) ? w_grant_onehot : '0;
    assign req_done  = r_done;
    assign cmd_valid = (r_state == S_ISSUE);
    assign cmd_addr  = r_cmd_addr;
    assign cmd_len   = r_cmd_len;
    assign cmd_write = r_write;
    assign cmd_id    = r_id;
    assign busy      = (r_state != S_IDLE);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_dma_burst_scheduler.sv
// Testbench for dma_burst_scheduler: directed scenarios plus a randomized
// phase, checked by a scoreboard whose expected bursts are computed from the
// request parameters with plain arithmetic at grant time.
module tb_dma_burst_scheduler;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [2:0]  req_valid, req_ready, req_write, req_done;
    logic [95:0] req_addr;
    logic [47:0] req_beats;
    logic        cmd_valid, cmd_ready, cmd_write, burst_done, busy, err;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [1:0]  cmd_id, dbg_state;

    dma_burst_scheduler #(.TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_beats(req_beats), .req_write(req_write), .req_done(req_done),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_len(cmd_len), .cmd_write(cmd_write), .cmd_id(cmd_id),
        .burst_done(burst_done), .busy(busy), .err(err), .dbg_state(dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;

    logic [42:0] exp_cmd_q[$];   // {id, write, len, addr}
    logic [1:0]  exp_done_q[$];
    logic [42:0] cmd_log[$];
    logic [1:0]  done_log[$];

    int m_ptr    = 0;            // reference round-robin pointer
    bit m_active = 1'b0;         // reference: a transfer is in progress

    logic [2:0]  s_req_ready, s_req_done;
    logic        s_cmd_valid, s_err;
    logic [1:0]  s_state;
    logic [42:0] s_cmd;

    // responder controls
    int rsp_mode   = 0;          // 0 ready always, 1 random, 2 held low
    int rsp_dmin   = 0;
    int rsp_dmax   = 0;
    bit rsp_spur   = 1'b0;
    bit rsp_nodone = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: split a request into bursts from the rules, not the RTL.
    function automatic void push_expected(input int id);
        logic [31:0] a;
        int rem, to_bnd, bl;
        a   = req_addr[id*32 +: 32] & 32'hFFFF_FFF0;
        rem = int'(req_beats[id*16 +: 16]);
        while (rem > 0) begin
            to_bnd = (4096 - int'(a % 4096)) / 16;
            bl = rem;
            if (bl > 256)    bl = 256;
            if (bl > to_bnd) bl = to_bnd;
            exp_cmd_q.push_back({2'(id), req_write[id], 8'(bl - 1), a});
            a   = a + 32'(bl * 16);
            rem = rem - bl;
        end
        exp_done_q.push_back(2'(id));
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_req(input int i, input logic [31:0] a, input logic [15:0] b, input logic w);
        req_addr[i*32 +: 32]  = a;
        req_beats[i*16 +: 16] = b;
        req_write[i]          = w;
        req_valid[i]          = 1'b1;
    endtask

    task automatic random_req(input int i);
        logic [31:0] a;
        int b, sel;
        a = $urandom();
        if ($urandom_range(0, 7) == 0) a = 32'hFFFF_F000 | 32'($urandom_range(0, 4095));
        sel = $urandom_range(0, 7);
        if (sel == 0)      b = 0;
        else if (sel <= 4) b = $urandom_range(1, 64);
        else               b = $urandom_range(65, 700);
        set_req(i, a, 16'(b), 1'($urandom_range(0, 1)));
    endtask

    // One cycle: check the grant against the reference arbiter at the
    // negedge, then drop the granted request just after the posedge.
    task automatic tick();
        logic [2:0] exp_rdy, drop;
        int g, idx;
        @(negedge clk);
        s_req_ready = req_ready;
        s_req_done  = req_done;
        s_cmd_valid = cmd_valid;
        s_state     = dbg_state;
        s_err       = err;
        s_cmd       = {cmd_id, cmd_write, cmd_len, cmd_addr};
        drop = 3'b000;
        if (!rst) begin
            if (req_done != 3'b000) m_active = 1'b0;
            exp_rdy = 3'b000;
            g = -1;
            if (!m_active) begin
                for (int k = 0; k < 3; k++) begin
                    idx = (m_ptr + k) % 3;
                    if (g < 0 && req_valid[idx]) g = idx;
                end
            end
            if (g >= 0) exp_rdy[g] = 1'b1;
            check("req_ready", req_ready, exp_rdy);
            if (g >= 0) begin
                push_expected(g);
                m_ptr    = (g + 1) % 3;
                m_active = 1'b1;
                drop[g]  = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        req_valid = req_valid & ~drop;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (!(exp_cmd_q.size() == 0 && exp_done_q.size() == 0 && !m_active && req_valid == 3'b000)
               && n < budget) begin
            tick();
            n++;
        end
        check({name, "_idle_in_budget"}, (n < budget), 1);
    endtask

    // ---------------- AXI master responder ----------------
    initial begin
        bit hs, outst;
        int dly;
        cmd_ready  = 1'b0;
        burst_done = 1'b0;
        outst = 1'b0;
        dly   = 0;
        forever begin
            @(negedge clk);
            hs = cmd_valid && cmd_ready && !rst;
            @(posedge clk);
            #1;
            burst_done = 1'b0;
            if (rst) begin
                outst     = 1'b0;
                cmd_ready = 1'b0;
            end else begin
                if (hs) begin
                    check("one_burst_outstanding", outst, 0);
                    outst = 1'b1;
                    dly   = $urandom_range(rsp_dmax, rsp_dmin);
                end
                if (outst && !rsp_nodone) begin
                    if (dly == 0) begin
                        burst_done = 1'b1;
                        outst      = 1'b0;
                    end else begin
                        dly--;
                    end
                end else if (!outst && rsp_spur && $urandom_range(0, 5) == 0) begin
                    burst_done = 1'b1;
                end
                case (rsp_mode)
                    0:       cmd_ready = 1'b1;
                    1:       cmd_ready = ($urandom_range(0, 2) != 0);
                    default: cmd_ready = 1'b0;
                endcase
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        bit pend;
        logic [42:0] prev, cur;
        logic [1:0] e;
        pend = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend = 1'b0;
            end else begin
                cur = {cmd_id, cmd_write, cmd_len, cmd_addr};
                if (pend) begin
                    check("cmd_valid_held", cmd_valid, 1);
                    check("cmd_fields_held", cur, prev);
                end
                if (cmd_valid) check("busy_when_cmd", busy, 1);
                if (cmd_valid && cmd_ready) begin
                    cmd_log.push_back(cur);
                    if (exp_cmd_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL cmd_unexpected: got cmd 0x%0h expected none", cur);
                    end else begin
                        check("cmd", cur, exp_cmd_q.pop_front());
                    end
                end
                if (req_done != 3'b000) begin
                    if (exp_done_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL done_unexpected: got req_done 0x%0h expected none", req_done);
                    end else begin
                        e = exp_done_q.pop_front();
                        done_log.push_back(e);
                        check("req_done", req_done, 3'b001 << e);
                    end
                end
                pend = cmd_valid && !cmd_ready;
                prev = cur;
            end
        end
    end

    // ---------------- global time limit ----------------
    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got no finish expected finish before limit");
        $fatal(1, "time limit");
    end

    // ---------------- main sequence ----------------
    initial begin
        int base, dbase, n, cnt;
        bit re;
        logic [42:0] e;

        rst       = 1'b1;
        req_valid = 3'b000;
        req_write = 3'b000;
        req_addr  = '0;
        req_beats = '0;

        // all three requesters present from reset, 16 beats each
        set_req(0, 32'h0000_0000, 16, 1'b0);
        set_req(1, 32'h0000_1000, 16, 1'b0);
        set_req(2, 32'h0000_2000, 16, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_req_done", req_done, 0);
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_cmd_addr", cmd_addr, 0);
        check("rst_cmd_len", cmd_len, 0);
        check("rst_cmd_write", cmd_write, 0);
        check("rst_cmd_id", cmd_id, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_state", dbg_state, 0);
        rst = 1'b0;

        // round-robin: 0,1,2 then re-asserted 0
        base = cmd_log.size();
        re = 1'b0;
        n = 0;
        while ((cmd_log.size() - base < 4 || exp_done_q.size() != 0 || m_active || req_valid != 3'b000)
               && n < 600) begin
            tick();
            n++;
            if (!re && s_req_ready[0]) begin
                set_req(0, 32'h0000_8000, 16, 1'b0);
                re = 1'b1;
            end
        end
        check("rr_cmd_count", cmd_log.size() - base, 4);
        if (cmd_log.size() - base >= 4) begin
            e = cmd_log[base + 0]; check("rr_id0", e[42:41], 0);
            e = cmd_log[base + 1]; check("rr_id1", e[42:41], 1);
            e = cmd_log[base + 2]; check("rr_id2", e[42:41], 2);
            e = cmd_log[base + 3]; check("rr_id3", e[42:41], 0);
        end

        // boundary split, plus request-to-command latency
        base  = cmd_log.size();
        dbase = done_log.size();
        set_req(0, 32'h0000_0F00, 300, 1'b0);
        tick();
        check("split_grant", s_req_ready, 3'b001);
        tick();
        check("lat_calc_no_cmd", s_cmd_valid, 0);
        tick();
        check("lat_cmd_at_2", s_cmd_valid, 1);
        wait_idle("split", 200);
        check("split_cmd_count", cmd_log.size() - base, 3);
        if (cmd_log.size() - base >= 3) begin
            check("split_b0", cmd_log[base + 0], {2'd0, 1'b0, 8'd15,  32'h0000_0F00});
            check("split_b1", cmd_log[base + 1], {2'd0, 1'b0, 8'd255, 32'h0000_1000});
            check("split_b2", cmd_log[base + 2], {2'd0, 1'b0, 8'd27,  32'h0000_2000});
        end
        check("split_done_count", done_log.size() - dbase, 1);

        // backpressure: cmd_ready low for 10 cycles
        rsp_mode = 2;
        base = cmd_log.size();
        set_req(2, 32'h0000_3000, 8, 1'b1);
        repeat (3) tick();
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_cmd_valid", s_cmd_valid, 1);
            check("bp_cmd_fields", s_cmd, {2'd2, 1'b1, 8'd7, 32'h0000_3000});
        end
        check("bp_none_accepted", cmd_log.size() - base, 0);
        rsp_mode = 0;
        wait_idle("bp", 100);
        check("bp_one_accepted", cmd_log.size() - base, 1);

        // zero-length request
        base = cmd_log.size();
        set_req(1, 32'h0000_0040, 0, 1'b0);
        tick();
        check("zl_grant", s_req_ready, 3'b010);
        check("zl_no_done_yet", s_req_done, 0);
        tick();
        check("zl_done", s_req_done, 3'b010);
        check("zl_no_cmd", s_cmd_valid, 0);
        tick();
        check("zl_idle", s_state, 0);
        check("zl_no_cmd_count", cmd_log.size() - base, 0);

        // randomized traffic with random backpressure, delays, stray burst_done
        rsp_mode = 1;
        rsp_dmin = 0;
        rsp_dmax = 4;
        rsp_spur = 1'b1;
        n = 0;
        cnt = 0;
        while ((cnt < 40 || exp_cmd_q.size() != 0 || exp_done_q.size() != 0 || m_active
                || req_valid != 3'b000) && n < 30000) begin
            tick();
            n++;
            for (int i = 0; i < 3; i++) begin
                if (!req_valid[i] && cnt < 40 && $urandom_range(0, 3) == 0) begin
                    random_req(i);
                    cnt++;
                end
            end
        end
        check("rand_in_budget", (n < 30000), 1);
        check("rand_err_clear", err, 0);
        rsp_mode = 0;
        rsp_spur = 1'b0;

        // reset while a burst is outstanding
        rsp_dmin = 30;
        rsp_dmax = 30;
        set_req(0, 32'h0000_5000, 64, 1'b0);
        n = 0;
        while (s_state != 2'd3 && n < 20) begin
            tick();
            n++;
        end
        check("mid_reached_wait", s_state, 3);
        rst = 1'b1;
        req_valid = 3'b000;
        #1;
        check("mid_rst_cmd_valid", cmd_valid, 0);
        check("mid_rst_req_done", req_done, 0);
        check("mid_rst_req_ready", req_ready, 0);
        check("mid_rst_cmd_addr", cmd_addr, 0);
        check("mid_rst_cmd_len", cmd_len, 0);
        check("mid_rst_cmd_id", cmd_id, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_state", dbg_state, 0);
        exp_cmd_q.delete();
        exp_done_q.delete();
        m_ptr    = 0;
        m_active = 1'b0;
        rsp_dmin = 0;
        rsp_dmax = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        dbase = done_log.size();
        set_req(2, 32'h0000_0100, 4, 1'b0);
        tick();
        check("restart_grant", s_req_ready, 3'b100);
        tick();
        check("restart_lat_calc", s_cmd_valid, 0);
        tick();
        check("restart_lat_cmd", s_cmd_valid, 1);
        check("restart_cmd", s_cmd, {2'd2, 1'b0, 8'd3, 32'h0000_0100});
        wait_idle("restart", 50);
        check("restart_done_count", done_log.size() - dbase, 1);
        check("pre_wd_err", err, 0);

`ifdef DMA_SCHED_WATCHDOG_EN
        // watchdog: burst_done withheld
        rsp_nodone = 1'b1;
        set_req(1, 32'h0000_0200, 16, 1'b0);
        n = 0;
        while (s_state != 2'd3 && n < 20) begin
            tick();
            n++;
        end
        check("wd_reached_wait", s_state, 3);
        cnt = 0;
        while (!s_err && cnt < 200) begin
            tick();
            cnt++;
        end
        check("wd_err_cycle", cnt, 100);
        check("wd_idle", s_state, 0);
        exp_done_q.delete();
        m_active = 1'b0;
        repeat (5) tick();
        check("wd_err_sticky", s_err, 1);
        check("wd_no_done", s_req_done, 0);
`endif

        check("end_exp_cmd_empty", exp_cmd_q.size(), 0);
        check("end_exp_done_empty", exp_done_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
